// File: rtl/game_session_ctrl_pkg.sv
// rtl/game_session_ctrl_pkg.sv - shared state encodings and BCD digit constants
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PLAYING    = 3'd1,
    ST_HIT        = 3'd2,
    ST_INVINCIBLE = 3'd3,
    ST_PAUSED     = 3'd4,
    ST_GAME_OVER  = 3'd5
  } state_e;

  localparam logic [3:0] BCD_ZERO = 4'h0;
  localparam logic [3:0] BCD_ONE  = 4'h1;
  localparam logic [3:0] BCD_NINE = 4'h9;

endpackage

// File: rtl/game_session_ctrl_if.sv
// rtl/game_session_ctrl_if.sv - player/obstacle request inputs and session status outputs
interface game_session_ctrl_if #(parameter int DIGITS = 4);

  logic                  collision_in;
  logic                  start_req;
  logic                  pause_req;
  logic                  restart_req;
  logic [2:0]            state_o;
  logic                  game_active;
  logic                  enable_player_move;
  logic                  enable_obstacles;
  logic                  invincible;
  logic [3:0]            lives;
  logic [3:0]            level;
  logic [4*DIGITS-1:0]   score_bcd;
  logic [4*DIGITS-1:0]   high_bcd;
  logic                  level_up;
  logic                  new_high;

  modport master (
    output collision_in, start_req, pause_req, restart_req,
    input  state_o, game_active, enable_player_move, enable_obstacles, invincible,
    input  lives, level, score_bcd, high_bcd, level_up, new_high
  );

  modport slave (
    input  collision_in, start_req, pause_req, restart_req,
    output state_o, game_active, enable_player_move, enable_obstacles, invincible,
    output lives, level, score_bcd, high_bcd, level_up, new_high
  );

endinterface

// File: rtl/game_session_ctrl_bcd_counter.sv
// rtl/game_session_ctrl_bcd_counter.sv - saturating packed BCD counter with clear and all-nines detect
module bcd_counter
  import game_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                clr,
  input  logic                inc,
  output logic [4*DIGITS-1:0] count,
  output logic                all_nines
);

  logic [4*DIGITS-1:0] count_d;
  logic                carry;

  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (count[4*i +: 4] != BCD_NINE) all_nines = 1'b0;
    end
  end

  // Ripple the carry digit by digit; blocked entirely at all nines so nothing wraps.
  always_comb begin
    count_d = count;
    carry   = inc & ~all_nines;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == BCD_NINE) begin
          count_d[4*i +: 4] = BCD_ZERO;
        end else begin
          count_d[4*i +: 4] = count[4*i +: 4] + BCD_ONE;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || clr) count <= '0;
    else              count <= count_d;
  end

endmodule

// File: rtl/game_session_ctrl.sv
// rtl/game_session_ctrl.sv - game session FSM: lives, timed hit/invincibility, pause, score, level, high score
module game_session_ctrl
  import game_pkg::*;
#(
  parameter int START_LIVES   = 3,
  parameter int DIGITS        = 4,
  parameter int TICK_CYCLES   = 50000000,
  parameter int HIT_CYCLES    = 25000000,
  parameter int INVULN_CYCLES = 100000000,
  parameter int LEVEL_STEP    = 10,
  parameter int MAX_LEVEL     = 7
) (
  input  logic              Clock,
  input  logic              Reset,
  game_session_ctrl_if.slave bus
);

  localparam int TMR_MAX = (HIT_CYCLES > INVULN_CYCLES) ? HIT_CYCLES : INVULN_CYCLES;
  localparam int TICK_W  = $clog2(TICK_CYCLES) + 1;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam int STEP_W  = $clog2(LEVEL_STEP) + 1;

  state_e              state_q, state_d, ret_q;
  logic                col_q, pause_q, restart_q;
  logic                col_edge, pause_edge, restart_edge;
  logic [TICK_W-1:0]   tick_q;
  logic [TMR_W-1:0]    tmr_q;
  logic [STEP_W-1:0]   step_q;
  logic [3:0]          lives_q, level_q;
  logic [4*DIGITS-1:0] score, high_q;
  logic                all_nines, tmr_clr, tmr_run, tick_run, tick_wrap, score_step, clr_all;
  logic                active_q, move_q, obst_q, inv_q, active_d, move_d, obst_d, inv_d;
  logic                level_up_q, new_high_q;

  assign col_edge     = bus.collision_in & ~col_q;
  assign pause_edge   = bus.pause_req    & ~pause_q;
  assign restart_edge = bus.restart_req  & ~restart_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      active_q <= 1'b0;
      move_q   <= 1'b1;
      obst_q   <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      move_q   <= move_d;
      obst_q   <= obst_d;
      inv_q    <= inv_d;
    end
  end

  // Collision outranks pause in PLAYING; in INVINCIBLE a pause outranks the timeout.
  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    tmr_run = 1'b0;
    case (state_q)
      ST_IDLE:       if (bus.start_req) state_d = ST_PLAYING;
      ST_PLAYING: begin
        if (col_edge) begin
          state_d = (lives_q == 4'd1) ? ST_GAME_OVER : ST_HIT;
          tmr_clr = 1'b1;
        end else if (pause_edge) begin
          state_d = ST_PAUSED;
        end
      end
      ST_HIT: begin
        if (tmr_q == TMR_W'(HIT_CYCLES - 1)) begin
          state_d = ST_INVINCIBLE;
          tmr_clr = 1'b1;
        end else begin
          tmr_run = 1'b1;
        end
      end
      ST_INVINCIBLE: begin
        if (pause_edge) begin
          state_d = ST_PAUSED;
        end else if (tmr_q == TMR_W'(INVULN_CYCLES - 1)) begin
          state_d = ST_PLAYING;
          tmr_clr = 1'b1;
        end else begin
          tmr_run = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (restart_edge)    state_d = ST_IDLE;
        else if (pause_edge) state_d = ret_q;
      end
      ST_GAME_OVER:  if (restart_edge) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase

    active_d = (state_d == ST_PLAYING) || (state_d == ST_HIT) ||
               (state_d == ST_INVINCIBLE) || (state_d == ST_PAUSED);
    obst_d   = (state_d == ST_PLAYING) || (state_d == ST_INVINCIBLE);
    move_d   = (state_d == ST_IDLE) || (state_d == ST_PLAYING) ||
               (state_d == ST_HIT) || (state_d == ST_INVINCIBLE);
    inv_d    = (state_d == ST_HIT) || (state_d == ST_INVINCIBLE);
  end

  assign tick_run   = ((state_q == ST_PLAYING) || (state_q == ST_INVINCIBLE)) && (state_d != ST_PAUSED);
  assign tick_wrap  = tick_run && (tick_q == TICK_W'(TICK_CYCLES - 1));
  assign score_step = tick_wrap && !all_nines;
  assign clr_all    = (state_d == ST_IDLE);

  bcd_counter #(.DIGITS(DIGITS)) u_score (
    .Clock     (Clock),
    .Reset     (Reset),
    .clr       (clr_all),
    .inc       (tick_wrap),
    .count     (score),
    .all_nines (all_nines)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      col_q      <= 1'b0;
      pause_q    <= 1'b0;
      restart_q  <= 1'b0;
      ret_q      <= ST_IDLE;
      tick_q     <= '0;
      tmr_q      <= '0;
      step_q     <= '0;
      lives_q    <= 4'(START_LIVES);
      level_q    <= 4'd1;
      high_q     <= '0;
      level_up_q <= 1'b0;
      new_high_q <= 1'b0;
    end else begin
      col_q      <= bus.collision_in;
      pause_q    <= bus.pause_req;
      restart_q  <= bus.restart_req;
      level_up_q <= 1'b0;
      new_high_q <= 1'b0;
      if (state_d == ST_PAUSED && state_q != ST_PAUSED) ret_q <= state_q;
      if (clr_all) begin
        tick_q  <= '0;
        tmr_q   <= '0;
        step_q  <= '0;
        lives_q <= 4'(START_LIVES);
        level_q <= 4'd1;
      end else begin
        if (tmr_clr)      tmr_q <= '0;
        else if (tmr_run) tmr_q <= tmr_q + TMR_W'(1);
        if (tick_run) tick_q <= tick_wrap ? '0 : tick_q + TICK_W'(1);
        if (state_q == ST_PLAYING && col_edge) lives_q <= lives_q - 4'd1;
        if (score_step) begin
          if (step_q == STEP_W'(LEVEL_STEP - 1)) begin
            step_q <= '0;
            if (level_q < 4'(MAX_LEVEL)) begin
              level_q    <= level_q + 4'd1;
              level_up_q <= 1'b1;
            end
          end else begin
            step_q <= step_q + STEP_W'(1);
          end
        end
        // Packed BCD orders like binary, so a plain compare suffices; score is frozen here.
        if (state_q == ST_GAME_OVER && score > high_q) begin
          high_q     <= score;
          new_high_q <= 1'b1;
        end
      end
    end
  end

  assign bus.state_o            = state_q;
  assign bus.game_active        = active_q;
  assign bus.enable_player_move = move_q;
  assign bus.enable_obstacles   = obst_q;
  assign bus.invincible         = inv_q;
  assign bus.lives              = lives_q;
  assign bus.level              = level_q;
  assign bus.score_bcd          = score;
  assign bus.high_bcd           = high_q;
  assign bus.level_up           = level_up_q;
  assign bus.new_high           = new_high_q;

endmodule

// File: tb/tb_game_session_ctrl.sv
// tb/tb_game_session_ctrl.sv - directed self-checking bench for game_session_ctrl
module tb_game_session_ctrl;
  import game_pkg::*;

  logic Clock;
  logic Reset;
  int   total  = 0;
  int   passed = 0;

  game_session_ctrl_if #(.DIGITS(4)) bus ();

  game_session_ctrl #(
    .START_LIVES(3), .DIGITS(4), .TICK_CYCLES(4), .HIT_CYCLES(3),
    .INVULN_CYCLES(8), .LEVEL_STEP(2), .MAX_LEVEL(3)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic       col;
    logic [2:0] st;
    logic [3:0] lv;
  } vec_t;

  vec_t tbl [12];

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // {game_active, enable_player_move, enable_obstacles, invincible}
  function automatic logic [3:0] exp_flags(input logic [2:0] st);
    case (st)
      3'd0:    return 4'b0100;
      3'd1:    return 4'b1110;
      3'd2:    return 4'b1101;
      3'd3:    return 4'b1111;
      3'd4:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] got_flags();
    return {bus.game_active, bus.enable_player_move, bus.enable_obstacles, bus.invincible};
  endfunction

  initial begin
    int nlu, nh, n;
    logic [15:0] s1, s2;

    tbl[0]  = '{1'b1, ST_HIT,        4'd2};
    tbl[1]  = '{1'b0, ST_HIT,        4'd2};
    tbl[2]  = '{1'b1, ST_HIT,        4'd2};
    tbl[3]  = '{1'b0, ST_INVINCIBLE, 4'd2};
    tbl[4]  = '{1'b1, ST_INVINCIBLE, 4'd2};
    tbl[5]  = '{1'b0, ST_INVINCIBLE, 4'd2};
    tbl[6]  = '{1'b0, ST_INVINCIBLE, 4'd2};
    tbl[7]  = '{1'b0, ST_INVINCIBLE, 4'd2};
    tbl[8]  = '{1'b0, ST_INVINCIBLE, 4'd2};
    tbl[9]  = '{1'b0, ST_INVINCIBLE, 4'd2};
    tbl[10] = '{1'b0, ST_INVINCIBLE, 4'd2};
    tbl[11] = '{1'b0, ST_PLAYING,    4'd2};

    bus.collision_in = 1'b0;
    bus.start_req    = 1'b0;
    bus.pause_req    = 1'b0;
    bus.restart_req  = 1'b0;
    Reset = 1'b1;
    cyc(2);
    Reset = 1'b0;
    check("rst_state", bus.state_o, 32'(ST_IDLE));
    check("rst_lives", bus.lives, 3);
    check("rst_level", bus.level, 1);
    check("rst_score", bus.score_bcd, 0);
    check("rst_high", bus.high_bcd, 0);
    check("rst_flags", got_flags(), 4'b0100);
    check("rst_pulses", {bus.level_up, bus.new_high}, 0);

    // Start and run 40 cycles of play: ten score points, level saturates at 3.
    bus.start_req = 1'b1;
    cyc(1);
    bus.start_req = 1'b0;
    check("start_state", bus.state_o, 32'(ST_PLAYING));
    check("start_flags", got_flags(), exp_flags(ST_PLAYING));
    nlu = 0; s1 = '0; s2 = '0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (bus.level_up) begin
        nlu++;
        if (nlu == 1) s1 = bus.score_bcd;
        if (nlu == 2) s2 = bus.score_bcd;
      end
    end
    check("play40_score", bus.score_bcd, 16'h0010);
    check("level_up_count", nlu, 2);
    check("level_up_at_2", s1, 16'h0002);
    check("level_up_at_4", s2, 16'h0004);
    check("level_sat", bus.level, 3);

    // Collision into HIT (3 cycles), INVINCIBLE (8 cycles); hits there are ignored.
    for (int i = 0; i < 12; i++) begin
      bus.collision_in = tbl[i].col;
      cyc(1);
      check($sformatf("vec%0d_state", i), bus.state_o, tbl[i].st);
      check($sformatf("vec%0d_lives", i), bus.lives, tbl[i].lv);
      check($sformatf("vec%0d_flags", i), got_flags(), exp_flags(tbl[i].st));
    end

    // Two more collisions end the game.
    bus.collision_in = 1'b1;
    cyc(1);
    bus.collision_in = 1'b0;
    check("hit2_state", bus.state_o, 32'(ST_HIT));
    check("hit2_lives", bus.lives, 1);
    cyc(11);
    check("hit2_back_play", bus.state_o, 32'(ST_PLAYING));
    bus.collision_in = 1'b1;
    cyc(1);
    bus.collision_in = 1'b0;
    check("go_state", bus.state_o, 32'(ST_GAME_OVER));
    check("go_lives", bus.lives, 0);
    check("go_flags", got_flags(), 4'b0000);
    nh = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (bus.new_high) nh++;
    end
    check("new_high_once", nh, 1);
    check("go_high", bus.high_bcd, 16'h0014);
    check("go_score_frozen", bus.score_bcd, 16'h0014);

    bus.restart_req = 1'b1;
    cyc(1);
    bus.restart_req = 1'b0;
    check("restart_state", bus.state_o, 32'(ST_IDLE));
    check("restart_score", bus.score_bcd, 0);
    check("restart_high", bus.high_bcd, 16'h0014);
    check("restart_lives", bus.lives, 3);

    // Pause inside INVINCIBLE at timer 5, then resume.
    bus.start_req = 1'b1;
    cyc(1);
    bus.start_req = 1'b0;
    bus.collision_in = 1'b1;
    cyc(1);
    bus.collision_in = 1'b0;
    cyc(3);
    check("p_inv_entry", bus.state_o, 32'(ST_INVINCIBLE));
    cyc(5);
    bus.pause_req = 1'b1;
    cyc(1);
    check("p_state", bus.state_o, 32'(ST_PAUSED));
    check("p_flags", got_flags(), exp_flags(ST_PAUSED));
    check("p_score", bus.score_bcd, 16'h0001);
    cyc(20);
    bus.pause_req = 1'b0;
    cyc(1);
    check("p_hold_state", bus.state_o, 32'(ST_PAUSED));
    check("p_hold_score", bus.score_bcd, 16'h0001);
    bus.pause_req = 1'b1;
    cyc(1);
    bus.pause_req = 1'b0;
    n = 0;
    while (bus.state_o == ST_INVINCIBLE && n < 20) begin
      n++;
      cyc(1);
    end
    check("p_inv_remaining", n, 3);
    check("p_resume_state", bus.state_o, 32'(ST_PLAYING));
    check("p_resume_score", bus.score_bcd, 16'h0002);

    // Long run to saturation at 9999.
    n = 0;
    while (bus.score_bcd != 16'h9998 && n < 45000) begin
      n++;
      cyc(1);
    end
    check("reach_9998", bus.score_bcd, 16'h9998);
    cyc(12);
    check("sat_9999", bus.score_bcd, 16'h9999);
    cyc(8);
    check("sat_hold", bus.score_bcd, 16'h9999);
    check("sat_level", bus.level, 3);

    // Reset in the middle of HIT.
    bus.collision_in = 1'b1;
    cyc(1);
    bus.collision_in = 1'b0;
    check("mh_state", bus.state_o, 32'(ST_HIT));
    check("mh_lives", bus.lives, 1);
    check("mh_high", bus.high_bcd, 16'h0014);
    cyc(1);
    Reset = 1'b1;
    cyc(1);
    Reset = 1'b0;
    check("mr_state", bus.state_o, 32'(ST_IDLE));
    check("mr_lives", bus.lives, 3);
    check("mr_high", bus.high_bcd, 0);
    check("mr_score", bus.score_bcd, 0);
    check("mr_level", bus.level, 1);
    check("mr_pulses", {bus.level_up, bus.new_high}, 0);
    check("mr_flags", got_flags(), 4'b0100);
    cyc(1);
    check("mr_stay_idle", bus.state_o, 32'(ST_IDLE));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
